// File: rtl/kamacore_pipeline_ctrl.sv
// rtl/kamacore_pipeline_ctrl.sv - hazard and pipeline-control unit for the kamacore in-order pipeline
//
// Purpose:
//    Generates the PC hold plus per-pipeline-register hold and flush vectors
//    for an NUM_STAGES-deep in-order pipeline. Pipeline registers are indexed
//    0 (IF/ID) to NUM_STAGES-2 (MEM/WB). There are three stall sources, listed
//    from highest to lowest priority:
//       - data-memory back-pressure (mem_busy), watched by a timeout watchdog;
//       - load-use hazards, which insert LOAD_USE_CYCLES bubbles;
//       - taken branches resolved in ID, which flush IF/ID.
//    All outputs are combinational from the current state and inputs, so a
//    hazard takes effect in the same cycle it is presented.
//
// Optional feature:
//    KAMACORE_PIPELINE_PERF_EN adds the stall_cycles and flush_count
//    performance counters, both PERF_WIDTH bits wide and wrapping.
//
// Ports:
//    clk              clock; all state changes on the rising edge
//    rst              asynchronous active-low reset
//    id_rs1_a/_used   rs1 address of the ID instruction, and whether ID reads rs1
//    id_rs2_a/_used   rs2 address of the ID instruction, and whether ID reads rs2
//    ex_is_load       the EX instruction is a load
//    ex_rd_a          destination address of the EX instruction
//    branch_valid     ID has resolved a taken branch or jump
//    mem_busy         data memory cannot complete the MEM access this cycle
//    pc_hold          freeze the PC
//    stage_hold       per-register hold (keep contents)
//    stage_flush      per-register flush (load a bubble)
//    stall_cycles     [perf] number of cycles with pc_hold=1
//    flush_count      [perf] number of branch flushes of IF/ID
//    mem_timeout_err  sticky watchdog error

module kamacore_pipeline_ctrl #(
   parameter int NUM_STAGES      = 5,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int MEM_TIMEOUT     = 64,
   parameter int PERF_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_a,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_a,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic                      ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_a,
   input  logic                      branch_valid,
   input  logic                      mem_busy,
   output logic                      pc_hold,
   output logic [NUM_STAGES-2:0]     stage_hold,
   output logic [NUM_STAGES-2:0]     stage_flush,
`ifdef KAMACORE_PIPELINE_PERF_EN
   output logic [PERF_WIDTH-1:0]     stall_cycles,
   output logic [PERF_WIDTH-1:0]     flush_count,
`endif
   output logic                      mem_timeout_err
);

   localparam int NR     = NUM_STAGES - 1;
   localparam int LU_W   = $clog2(LOAD_USE_CYCLES + 1);
   localparam int BUSY_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit WD_EN  = (MEM_TIMEOUT > 0);

   localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(MEM_TIMEOUT);
   localparam logic [BUSY_W-1:0] BUSY_LAST = WD_EN ? BUSY_W'(MEM_TIMEOUT - 1) : '0;
   localparam logic [LU_W-1:0]   LU_LOAD   = LU_W'(LOAD_USE_CYCLES - 1);

   // Memory back-pressure: hold every register up to EX/MEM and bubble MEM/WB,
   // so the MEM-stage access is retried while the older WB instruction retires.
   localparam logic [NR-1:0] MEM_HOLD  = {1'b0, {(NR-1){1'b1}}};
   localparam logic [NR-1:0] MEM_FLUSH = {1'b1, {(NR-1){1'b0}}};
   // Load-use: keep the consumer in ID and send a bubble into EX.
   localparam logic [NR-1:0] LU_HOLD   = NR'(1);
   localparam logic [NR-1:0] LU_FLUSH  = NR'(2);
   localparam logic [NR-1:0] BR_FLUSH  = NR'(1);

   typedef enum logic {
      RUN,
      LU_STALL
   } state_t;

   state_t              state;
   logic [LU_W-1:0]     lu_cnt;
   logic [BUSY_W-1:0]   busy_cnt;
   logic                lu_hit;

   // Register x0 is hard-wired to zero, so a load targeting it never hazards.
   always_comb begin
      lu_hit = 1'b0;
      if (ex_is_load && (ex_rd_a != '0)) begin
         lu_hit = (id_rs1_used && (id_rs1_a == ex_rd_a)) ||
                  (id_rs2_used && (id_rs2_a == ex_rd_a));
      end
   end

   // Output decode. branch_valid is only honoured when nothing stalls ID;
   // a stalled branch is re-resolved once it advances.
   always_comb begin
      pc_hold     = 1'b0;
      stage_hold  = '0;
      stage_flush = '0;
      if (!rst) begin
         stage_flush = '1;
      end else if (mem_busy) begin
         pc_hold     = 1'b1;
         stage_hold  = MEM_HOLD;
         stage_flush = MEM_FLUSH;
      end else if ((state == LU_STALL) || lu_hit) begin
         pc_hold     = 1'b1;
         stage_hold  = LU_HOLD;
         stage_flush = LU_FLUSH;
      end else if (branch_valid) begin
         stage_flush = BR_FLUSH;
      end
   end

   // Load-use bubble sequencer. The first bubble is issued from RUN on the
   // hit itself; LU_STALL covers the remaining LOAD_USE_CYCLES-1 bubbles.
   // Memory back-pressure freezes the sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         lu_cnt <= '0;
      end else if (!mem_busy) begin
         case (state)
            RUN: begin
               if (lu_hit && (LOAD_USE_CYCLES > 1)) begin
                  state  <= LU_STALL;
                  lu_cnt <= LU_LOAD;
               end
            end
            LU_STALL: begin
               if (lu_cnt <= LU_W'(1)) begin
                  state  <= RUN;
                  lu_cnt <= '0;
               end else begin
                  lu_cnt <= lu_cnt - LU_W'(1);
               end
            end
            default: begin
               state  <= RUN;
               lu_cnt <= '0;
            end
         endcase
      end
   end

   // Watchdog on consecutive busy cycles. The error is raised on the edge
   // where the count reaches MEM_TIMEOUT and is cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else if (mem_busy) begin
         if (busy_cnt != BUSY_MAX) begin
            busy_cnt <= busy_cnt + BUSY_W'(1);
         end
         if (WD_EN && (busy_cnt == BUSY_LAST)) begin
            mem_timeout_err <= 1'b1;
         end
      end else begin
         busy_cnt <= '0;
      end
   end

`ifdef KAMACORE_PIPELINE_PERF_EN
   // Outside reset, stage_flush[0] is only raised by a branch flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (pc_hold) begin
            stall_cycles <= stall_cycles + PERF_WIDTH'(1);
         end
         if (stage_flush[0]) begin
            flush_count <= flush_count + PERF_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_kamacore_pipeline_ctrl.sv
// tb/tb_kamacore_pipeline_ctrl.sv - self-checking bench for kamacore_pipeline_ctrl
module tb_kamacore_pipeline_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       rs1u = 1'b0, rs2u = 1'b0, ld = 1'b0, br = 1'b0, busy = 1'b0;

   logic [1:0] pc_v, err_v;
   logic [3:0] hold_v [2];
   logic [3:0] flush_v [2];
`ifdef KAMACORE_PIPELINE_PERF_EN
   logic [31:0] sc_a, fc_a;
   logic [3:0]  sc_b, fc_b;
`endif

   kamacore_pipeline_ctrl dut_a (
      .clk(clk), .rst(rst),
      .id_rs1_a(rs1), .id_rs2_a(rs2), .id_rs1_used(rs1u), .id_rs2_used(rs2u),
      .ex_is_load(ld), .ex_rd_a(rd), .branch_valid(br), .mem_busy(busy),
      .pc_hold(pc_v[0]), .stage_hold(hold_v[0]), .stage_flush(flush_v[0]),
`ifdef KAMACORE_PIPELINE_PERF_EN
      .stall_cycles(sc_a), .flush_count(fc_a),
`endif
      .mem_timeout_err(err_v[0])
   );

   kamacore_pipeline_ctrl #(
      .LOAD_USE_CYCLES(3), .MEM_TIMEOUT(8), .PERF_WIDTH(4)
   ) dut_b (
      .clk(clk), .rst(rst),
      .id_rs1_a(rs1), .id_rs2_a(rs2), .id_rs1_used(rs1u), .id_rs2_used(rs2u),
      .ex_is_load(ld), .ex_rd_a(rd), .branch_valid(br), .mem_busy(busy),
      .pc_hold(pc_v[1]), .stage_hold(hold_v[1]), .stage_flush(flush_v[1]),
`ifdef KAMACORE_PIPELINE_PERF_EN
      .stall_cycles(sc_b), .flush_count(fc_b),
`endif
      .mem_timeout_err(err_v[1])
   );

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // rem  = load-use bubbles still owed after the current one
   // blen = length of the current run of busy cycles
   int          lu_cycles [2] = '{1, 3};
   int          timeout   [2] = '{64, 8};
   logic [31:0] pmask     [2] = '{32'hffff_ffff, 32'h0000_000f};
   int          rem  [2] = '{0, 0};
   int          blen [2] = '{0, 0};
   logic        merr [2] = '{1'b0, 1'b0};
   logic [31:0] msc  [2] = '{32'd0, 32'd0};
   logic [31:0] mfc  [2] = '{32'd0, 32'd0};

   function automatic logic hazard();
      return ld && (rd != 0) && ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
   endfunction

   function automatic logic [31:0] perf_sc(int k);
`ifdef KAMACORE_PIPELINE_PERF_EN
      return (k == 0) ? sc_a : {28'd0, sc_b};
`else
      return 32'(k) & 32'd0;
`endif
   endfunction

   function automatic logic [31:0] perf_fc(int k);
`ifdef KAMACORE_PIPELINE_PERF_EN
      return (k == 0) ? fc_a : {28'd0, fc_b};
`else
      return 32'(k) & 32'd0;
`endif
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic       epc, lus, brf;
         logic [3:0] eh, ef;
         if (!rst) begin
            rem[k] = 0; blen[k] = 0; merr[k] = 1'b0; msc[k] = 0; mfc[k] = 0;
         end
         epc = 1'b0; eh = 4'b0000; ef = 4'b0000; lus = 1'b0; brf = 1'b0;
         if (!rst) begin
            ef = 4'b1111;
         end else if (busy) begin
            epc = 1'b1; eh = 4'b0111; ef = 4'b1000;
         end else if (rem[k] > 0 || hazard()) begin
            epc = 1'b1; eh = 4'b0001; ef = 4'b0010; lus = 1'b1;
         end else if (br) begin
            ef = 4'b0001; brf = 1'b1;
         end
         check($sformatf("model pc_hold[%0d]", k), 32'(pc_v[k]), 32'(epc));
         check($sformatf("model stage_hold[%0d]", k), 32'(hold_v[k]), 32'(eh));
         check($sformatf("model stage_flush[%0d]", k), 32'(flush_v[k]), 32'(ef));
         check($sformatf("model timeout_err[%0d]", k), 32'(err_v[k]), 32'(merr[k]));
`ifdef KAMACORE_PIPELINE_PERF_EN
         check($sformatf("model stall_cycles[%0d]", k), perf_sc(k), msc[k]);
         check($sformatf("model flush_count[%0d]", k), perf_fc(k), mfc[k]);
`endif
         if (rst) begin
            if (busy) begin
               if (blen[k] < timeout[k]) blen[k]++;
               if (blen[k] >= timeout[k]) merr[k] = 1'b1;
            end else begin
               blen[k] = 0;
               if (rem[k] > 0) rem[k]--;
               else if (lus) rem[k] = lu_cycles[k] - 1;
            end
            if (epc) msc[k] = (msc[k] + 1) & pmask[k];
            if (brf) mfc[k] = (mfc[k] + 1) & pmask[k];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(logic l, logic [4:0] d, logic [4:0] a1, logic u1,
                         logic [4:0] a2, logic u2, logic b, logic m);
      ld = l; rd = d; rs1 = a1; rs1u = u1; rs2 = a2; rs2u = u2; br = b; busy = m;
   endtask

   task automatic drive(logic l, logic [4:0] d, logic [4:0] a1, logic u1,
                        logic [4:0] a2, logic u2, logic b, logic m);
      @(posedge clk);
      #1;
      set_in(l, d, a1, u1, a2, u2, b, m);
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic lu();
      drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mem();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic expect_out(string nm, int k, logic pc, logic [3:0] h, logic [3:0] f);
      check($sformatf("%s pc_hold[%0d]", nm, k), 32'(pc_v[k]), 32'(pc));
      check($sformatf("%s stage_hold[%0d]", nm, k), 32'(hold_v[k]), 32'(h));
      check($sformatf("%s stage_flush[%0d]", nm, k), 32'(flush_v[k]), 32'(f));
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   int burst = 0;

   initial begin
      // reset state
      @(posedge clk);
      #3;
      for (int k = 0; k < 2; k++) begin
         expect_out("reset", k, 1'b0, 4'b0000, 4'b1111);
         check($sformatf("reset err[%0d]", k), 32'(err_v[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      expect_out("idle", 0, 1'b0, 4'b0000, 4'b0000);
      expect_out("idle", 1, 1'b0, 4'b0000, 4'b0000);

      // load-use: one bubble on dut_a, three on dut_b
      lu();
      expect_out("lu hit", 0, 1'b1, 4'b0001, 4'b0010);
      expect_out("lu hit", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      expect_out("lu after", 0, 1'b0, 4'b0000, 4'b0000);
      expect_out("lu bubble2", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      expect_out("lu bubble3", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      expect_out("lu done", 1, 1'b0, 4'b0000, 4'b0000);

      // x0 never hazards
      drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      expect_out("x0", 0, 1'b0, 4'b0000, 4'b0000);
      expect_out("x0", 1, 1'b0, 4'b0000, 4'b0000);

      // branch alone, then branch with a hazard on rs2
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      expect_out("branch", 0, 1'b0, 4'b0000, 4'b0001);
      expect_out("branch", 1, 1'b0, 4'b0000, 4'b0001);
      drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
      expect_out("branch+lu", 0, 1'b1, 4'b0001, 4'b0010);
      expect_out("branch+lu", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      idle();
      idle();
      expect_out("branch+lu done", 1, 1'b0, 4'b0000, 4'b0000);

      // memory stall in the middle of a load-use stall
      lu();
      for (int i = 0; i < 4; i++) begin
         mem();
         expect_out("memstall", 0, 1'b1, 4'b0111, 4'b1000);
         expect_out("memstall", 1, 1'b1, 4'b0111, 4'b1000);
      end
      idle();
      expect_out("mem release", 0, 1'b0, 4'b0000, 4'b0000);
      expect_out("resume bubble2", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      expect_out("resume bubble3", 1, 1'b1, 4'b0001, 4'b0010);
      idle();
      expect_out("resume done", 1, 1'b0, 4'b0000, 4'b0000);

      // watchdog on dut_b (MEM_TIMEOUT=8)
      for (int i = 0; i < 7; i++) mem();
      idle();
      check("wd 7 cycles", 32'(err_v[1]), 32'd0);
      for (int i = 0; i < 8; i++) mem();
      idle();
      check("wd 8 cycles", 32'(err_v[1]), 32'd1);
      idle();
      check("wd sticky", 32'(err_v[1]), 32'd1);
      check("wd dut_a", 32'(err_v[0]), 32'd0);

      // reset in the middle of a load-use stall
      lu();
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      expect_out("rst mid", 1, 1'b0, 4'b0000, 4'b1111);
      check("rst err", 32'(err_v[1]), 32'd0);
      @(posedge clk);
      #3;
      expect_out("rst held", 1, 1'b0, 4'b0000, 4'b1111);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      expect_out("rst release", 1, 1'b0, 4'b0000, 4'b0000);

`ifdef KAMACORE_PIPELINE_PERF_EN
      pulse_reset();
      #2;
      check("perf reset sc", sc_a, 32'd0);
      check("perf reset fc", fc_a, 32'd0);
      lu();
      idle();
      lu();
      idle();
      idle();
      idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      idle();
      check("perf stall_cycles", sc_a, 32'd2);
      check("perf flush_count", fc_a, 32'd1);
      pulse_reset();
      for (int i = 0; i < 17; i++) mem();
      idle();
      check("perf wrap", 32'(sc_b), 32'd1);
      check("perf nowrap", sc_a, 32'd17);
`endif
      pulse_reset();

      // randomized phase, checked by the model every cycle
      for (int n = 0; n < 1500; n++) begin
         logic m;
         if (burst > 0) begin
            m = 1'b1;
            burst--;
         end else if ($urandom_range(0, 7) == 0) begin
            burst = $urandom_range(0, 11);
            m = 1'b1;
         end else begin
            m = 1'b0;
         end
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), m);
         rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/kamacore_pipeline_ctrl.md
Name: kamacore_pipeline_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the kamacore N-stage in-order pipeline.
- Drives per-register hold and flush vectors plus the PC hold, replacing today's tied-off hold inputs.
- Handles three stall sources:
  - load-use hazards, with a configurable bubble count;
  - data-memory back-pressure, with a timeout watchdog;
  - ID-resolved branch flushes.
- Sits beside the forwarding unit in the top level.

Parameters:
- NUM_STAGES, 5: pipeline stages. Pipeline registers are indexed 0 (IF/ID) to NUM_STAGES-2 (MEM/WB). Minimum value 4.
- REG_ADDR_WIDTH, 5: register address width.
- LOAD_USE_CYCLES, 1: bubbles inserted per load-use hazard. Minimum value 1.
- MEM_TIMEOUT, 64: consecutive mem_busy cycles before an error is flagged. 0 disables the watchdog.
- PERF_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-low.
- id_rs1_a  in  REG_ADDR_WIDTH  rs1 address of the instruction in ID.
- id_rs2_a  in  REG_ADDR_WIDTH  rs2 address of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd_a  in  REG_ADDR_WIDTH  destination address of the EX instruction.
- branch_valid  in  1  ID has resolved a taken branch or jump.
- mem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_hold  out  1  freeze the PC.
- stage_hold  out  NUM_STAGES-1  per-register hold (keep contents).
- stage_flush  out  NUM_STAGES-1  per-register flush (load a bubble).
- mem_timeout_err  out  1  sticky watchdog error.

Behaviour:
- State machine: RUN and LU_STALL. Internal counters:
  - lu_cnt, width clog2(LOAD_USE_CYCLES+1);
  - busy_cnt, saturating at MEM_TIMEOUT.
- Reset (rst=0, asynchronous):
  - state=RUN, lu_cnt=0, busy_cnt=0, mem_timeout_err=0.
  - Outputs while reset is asserted: pc_hold=0, stage_hold=0, stage_flush=all ones.
  - Reset mid-stall abandons the stall immediately.
- Outputs are combinational from state and current inputs (same-cycle effect). No added latency.
- Hazard term: lu_hit = ex_is_load and ex_rd_a!=0 and ((id_rs1_used and id_rs1_a==ex_rd_a) or (id_rs2_used and id_rs2_a==ex_rd_a)). Address 0 never hazards.
- Priority, highest first:
  1. mem_busy=1, any state:
     - pc_hold=1;
     - stage_hold[i]=1 for i=0..NUM_STAGES-3;
     - stage_flush[NUM_STAGES-2]=1;
     - state and lu_cnt frozen.
  2. RUN and lu_hit:
     - pc_hold=1, stage_hold[0]=1, stage_flush[1]=1.
     - If LOAD_USE_CYCLES>1: next state=LU_STALL, lu_cnt=LOAD_USE_CYCLES-1. Otherwise stay in RUN.
  3. LU_STALL:
     - Same outputs as priority 2.
     - lu_cnt decrements each cycle. Return to RUN on the cycle lu_cnt reaches 1 (last bubble).
  4. RUN and branch_valid: stage_flush[0]=1.
  5. Otherwise: all outputs 0.
- branch_valid is ignored under priorities 1–3; ID re-resolves the branch once it advances.
- stage_hold[i] and stage_flush[i] are never both 1 for the same i.
- Watchdog:
  - busy_cnt increments on each mem_busy=1 cycle and clears on each mem_busy=0 cycle.
  - When busy_cnt reaches MEM_TIMEOUT (MEM_TIMEOUT>0), mem_timeout_err is set and stays set until reset.
  - busy_cnt saturates; it does not wrap.

Optional Feature:
- Macro: KAMACORE_PIPELINE_PERF_EN.
- When defined, adds output ports:
  - stall_cycles, PERF_WIDTH: counts cycles with pc_hold=1;
  - flush_count, PERF_WIDTH: counts cycles with stage_flush[0]=1 caused by a branch.
- Both counters reset to 0 on rst and wrap modulo 2^PERF_WIDTH.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Load-use, defaults: ex_is_load=1, ex_rd_a=5, id_rs1_a=5, id_rs1_used=1 for one cycle.
  - Expect pc_hold=1, stage_hold=4'b0001, stage_flush=4'b0010 for exactly 1 cycle, then all zeros.
- LOAD_USE_CYCLES=3: same hit for one cycle.
  - Expect the stall outputs for 3 consecutive cycles, then RUN.
  - Repeat with ex_rd_a=0 and id_rs1_a=0: expect no stall.
- Branch vs hazard: branch_valid=1 with lu_hit=0 → stage_flush=4'b0001 for 1 cycle. branch_valid=1 with lu_hit=1 → load-use outputs only; stage_flush[0]=0.
- Memory stall:
  - mem_busy=1 for 4 cycles during LU_STALL (LOAD_USE_CYCLES=3) → stage_hold=4'b0111, stage_flush=4'b1000 for those 4 cycles, and lu_cnt frozen.
  - After release, the remaining bubbles complete.
- Watchdog, MEM_TIMEOUT=8:
  - mem_busy high for 7 cycles then low → mem_timeout_err=0.
  - mem_busy high for 8 cycles → mem_timeout_err=1 and stays 1 after mem_busy drops.
  - rst=0 mid-stall → all state cleared, stage_flush all ones while reset is held.
- KAMACORE_PIPELINE_PERF_EN, PERF_WIDTH=4:
  - 2 load-use stalls + 1 branch → stall_cycles=2, flush_count=1.
  - 17 stall cycles → stall_cycles=1 (wrap).
